// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

   // Operation encodings presented on the op port
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   // One quotient bit is produced per divide step
   localparam int DIV_STEPS = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DIV  = 2'b10,
      FIX  = 2'b11
   } state_t;

   // Magnitude of a 32-bit operand; only negates when the op is signed.
   // The most negative value maps to 0x80000000, which is correct as unsigned.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      logic [31:0] r;
      if (sgn && v[31]) begin
         r = 32'd0 - v;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration. The dividend is shifted out of the
// top of the quotient register into the partial remainder while quotient bits
// are shifted in at the bottom.
module div_step
   import muldiv_pkg::*;
(
   input  logic [31:0] rem_in,
   input  logic [31:0] quo_in,
   input  logic [31:0] divisor,
   output logic [31:0] rem_out,
   output logic [31:0] quo_out
);

   logic [32:0] shifted_s;

   // Trial subtract; keep the difference only when it does not go negative
   always_comb begin
      shifted_s = {rem_in, quo_in[31]};
      if (shifted_s >= {1'b0, divisor}) begin
         // result is below the divisor, so 32 bits always hold it
         rem_out = shifted_s[31:0] - divisor;
         quo_out = {quo_in[30:0], 1'b1};
      end else begin
         rem_out = shifted_s[31:0];
         quo_out = {quo_in[30:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO owner for the pipeline: fixed-latency multiply, 32-step restoring
// divide with a sign fix-up cycle, mthi/mtlo writes and exception cancel.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int MUL_LAT = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic        cancel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);
   localparam logic [4:0] DIV_CNT = 5'(DIV_STEPS - 1);

   state_t      state_r, state_nxt_s;
   logic [4:0]  cnt_r, cnt_nxt_s;
   logic [31:0] a_r, a_nxt_s;
   logic [31:0] b_r, b_nxt_s;
   logic        sgn_r, sgn_nxt_s;
   logic [31:0] rem_r, rem_nxt_s;
   logic [31:0] quo_r, quo_nxt_s;
   logic [31:0] dvs_r, dvs_nxt_s;
   logic [31:0] hi_r, hi_nxt_s;
   logic [31:0] lo_r, lo_nxt_s;
   logic        busy_r;

   logic [31:0] step_rem_s, step_quo_s;
   logic [63:0] prod_s;
   logic [31:0] quo_fix_s, rem_fix_s;

   div_step u_div_step (
      .rem_in  (rem_r),
      .quo_in  (quo_r),
      .divisor (dvs_r),
      .rem_out (step_rem_s),
      .quo_out (step_quo_s)
   );

   // Product and signed fix-up of the divide result from latched operands
   always_comb begin
      // sign-extending to 64 bits makes the truncated product correct for both signednesses
      prod_s = {{32{sgn_r & a_r[31]}}, a_r} * {{32{sgn_r & b_r[31]}}, b_r};
      if (sgn_r && (a_r[31] ^ b_r[31])) begin
         quo_fix_s = 32'd0 - quo_r;
      end else begin
         quo_fix_s = quo_r;
      end
      if (sgn_r && a_r[31]) begin
         rem_fix_s = 32'd0 - rem_r;
      end else begin
         rem_fix_s = rem_r;
      end
   end

   // Next-state and datapath update for the controller FSM
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      a_nxt_s     = a_r;
      b_nxt_s     = b_r;
      sgn_nxt_s   = sgn_r;
      rem_nxt_s   = rem_r;
      quo_nxt_s   = quo_r;
      dvs_nxt_s   = dvs_r;
      hi_nxt_s    = hi_r;
      lo_nxt_s    = lo_r;
      case (state_r)
         IDLE: begin
            if (cancel) begin
               state_nxt_s = IDLE;
            end else if (start) begin
               a_nxt_s   = a;
               b_nxt_s   = b;
               sgn_nxt_s = ~op[0];
               if (op[1] == 1'b0) begin
                  state_nxt_s = MUL;
                  cnt_nxt_s   = MUL_CNT;
               end else begin
                  state_nxt_s = DIV;
                  cnt_nxt_s   = DIV_CNT;
                  rem_nxt_s   = 32'd0;
                  quo_nxt_s   = mag32(a, ~op[0]);
                  dvs_nxt_s   = mag32(b, ~op[0]);
               end
            end else begin
               if (mthi) begin
                  hi_nxt_s = a;
               end else begin
                  hi_nxt_s = hi_r;
               end
               if (mtlo) begin
                  lo_nxt_s = a;
               end else begin
                  lo_nxt_s = lo_r;
               end
            end
         end
         MUL: begin
            if (cancel) begin
               state_nxt_s = IDLE;
            end else if (cnt_r == 5'd0) begin
               hi_nxt_s    = prod_s[63:32];
               lo_nxt_s    = prod_s[31:0];
               state_nxt_s = IDLE;
            end else begin
               cnt_nxt_s = cnt_r - 5'd1;
            end
         end
         DIV: begin
            if (cancel) begin
               state_nxt_s = IDLE;
            end else begin
               rem_nxt_s = step_rem_s;
               quo_nxt_s = step_quo_s;
               if (cnt_r == 5'd0) begin
                  state_nxt_s = FIX;
               end else begin
                  cnt_nxt_s = cnt_r - 5'd1;
               end
            end
         end
         FIX: begin
            state_nxt_s = IDLE;
            if (cancel) begin
               hi_nxt_s = hi_r;
            end else if (b_r == 32'd0) begin
               // divide by zero: all-ones quotient, dividend passed through as remainder
               lo_nxt_s = 32'hFFFF_FFFF;
               hi_nxt_s = a_r;
            end else begin
               lo_nxt_s = quo_fix_s;
               hi_nxt_s = rem_fix_s;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, operand latches and HI/LO registers; busy is registered from next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= 5'd0;
         a_r     <= 32'd0;
         b_r     <= 32'd0;
         sgn_r   <= 1'b0;
         rem_r   <= 32'd0;
         quo_r   <= 32'd0;
         dvs_r   <= 32'd0;
         hi_r    <= 32'd0;
         lo_r    <= 32'd0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         a_r     <= a_nxt_s;
         b_r     <= b_nxt_s;
         sgn_r   <= sgn_nxt_s;
         rem_r   <= rem_nxt_s;
         quo_r   <= quo_nxt_s;
         dvs_r   <= dvs_nxt_s;
         hi_r    <= hi_nxt_s;
         lo_r    <= lo_nxt_s;
         busy_r  <= (state_nxt_s != IDLE);
      end
   end

   assign busy = busy_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

   localparam int LAT_MUL = 5;
   localparam int LAT_DIV = 33;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic        cancel = 1'b0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors = 0;
   int errors  = 0;

   muldiv_unit #(.MUL_LAT(LAT_MUL)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .mthi   (mthi),
      .mtlo   (mtlo),
      .cancel (cancel),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: {hi, lo} computed directly from MIPS arithmetic rules
   function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] res;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'b00: begin
            q = sx * sy;
            res = q;
         end
         2'b01: res = {32'd0, x} * {32'd0, y};
         2'b10: begin
            if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
            else begin
               q = sx / sy;
               r = sx % sy;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
            else res = {x % y, x / y};
         end
      endcase
      return res;
   endfunction

   // Launch an op and count busy cycles; returns at the first non-busy sample
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int n);
      op = o; a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
      a = $urandom; b = $urandom;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
      a = hv; mthi = 1'b1; tick(); mthi = 1'b0;
      a = lv; mtlo = 1'b1; tick(); mtlo = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      vectors++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_hold: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
      end
      tick(); tick();
      reset = 1'b0;
      tick();
      vectors++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_release: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
      end
   endtask

   task automatic test_mult();
      int n;
      run_op(2'b00, 32'hFFFF_FFFF, 32'd2, n);
      vectors++; if (n != LAT_MUL) begin errors++; $display("FAIL mult_lat: got %0d expected %0d", n, LAT_MUL); end
      vectors++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         errors++; $display("FAIL mult_res: got %h_%h expected ffffffff_fffffffe", hi, lo);
      end
      run_op(2'b01, 32'hFFFF_FFFF, 32'd2, n);
      vectors++; if (n != LAT_MUL) begin errors++; $display("FAIL multu_lat: got %0d expected %0d", n, LAT_MUL); end
      vectors++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin
         errors++; $display("FAIL multu_res: got %h_%h expected 00000001_fffffffe", hi, lo);
      end
   endtask

   task automatic test_div();
      int n;
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, n);
      vectors++; if (n != LAT_DIV) begin errors++; $display("FAIL div_lat: got %0d expected %0d", n, LAT_DIV); end
      vectors++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL div_neg: got hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
      end
      run_op(2'b11, 32'd7, 32'd2, n);
      vectors++; if (lo !== 32'd3 || hi !== 32'd1 || n != LAT_DIV) begin
         errors++; $display("FAIL divu_small: got hi=%h lo=%h lat=%0d expected 1/3/33", hi, lo, n);
      end
      run_op(2'b11, 32'h0000_1234, 32'd0, n);
      vectors++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h0000_1234 || n != LAT_DIV) begin
         errors++; $display("FAIL divu_by_zero: got hi=%h lo=%h lat=%0d expected 1234/ffffffff/33", hi, lo, n);
      end
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
      vectors++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
         errors++; $display("FAIL div_overflow: got hi=%h lo=%h expected 0/80000000", hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo();
      a = 32'h0000_DEAD; mthi = 1'b1; tick(); mthi = 1'b0;
      vectors++; if (hi !== 32'h0000_DEAD) begin errors++; $display("FAIL mthi: got %h expected 0000dead", hi); end
      a = 32'h0000_BEEF; mthi = 1'b1; mtlo = 1'b1; tick(); mthi = 1'b0; mtlo = 1'b0;
      vectors++; if (hi !== 32'h0000_BEEF || lo !== 32'h0000_BEEF) begin
         errors++; $display("FAIL mthi_mtlo_both: got hi=%h lo=%h expected 0000beef/0000beef", hi, lo);
      end
   endtask

   task automatic test_busy_ignore();
      int n;
      op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         if (n < 2) begin
            start = 1'b1; mtlo = 1'b1; op = 2'b11; a = 32'h0000_5555;
         end else begin
            start = 1'b0; mtlo = 1'b0;
         end
         n++;
         tick();
      end
      start = 1'b0; mtlo = 1'b0;
      vectors++; if (n != LAT_MUL || lo !== 32'd12 || hi !== 32'd0) begin
         errors++; $display("FAIL busy_ignore: got hi=%h lo=%h lat=%0d expected 0/c/%0d", hi, lo, n, LAT_MUL);
      end
      tick();
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_relaunch: got busy=%b expected 0", busy); end
   endtask

   task automatic test_start_mthi();
      int n;
      a = 32'h0000_1111; mthi = 1'b1; tick(); mthi = 1'b0;
      op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1; mthi = 1'b1;
      tick();
      start = 1'b0; mthi = 1'b0;
      vectors++; if (hi !== 32'h0000_1111 || busy !== 1'b1) begin
         errors++; $display("FAIL start_mthi_prio: got hi=%h busy=%b expected 00001111/1", hi, busy);
      end
      n = 0;
      while (busy === 1'b1 && n < 100) begin n++; tick(); end
      vectors++; if (hi !== 32'd0 || lo !== 32'd6 || n != LAT_MUL) begin
         errors++; $display("FAIL start_mthi_res: got hi=%h lo=%h lat=%0d expected 0/6/%0d", hi, lo, n, LAT_MUL);
      end
   endtask

   task automatic test_cancel();
      write_hilo(32'd1, 32'd2);
      op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL cancel_pre: got busy=%b expected 1", busy); end
      cancel = 1'b1; tick(); cancel = 1'b0;
      vectors++; if (busy !== 1'b0 || hi !== 32'd1 || lo !== 32'd2) begin
         errors++; $display("FAIL cancel: got busy=%b hi=%h lo=%h expected 0/1/2", busy, hi, lo);
      end
      repeat (3) tick();
      vectors++; if (busy !== 1'b0 || hi !== 32'd1 || lo !== 32'd2) begin
         errors++; $display("FAIL cancel_after: got busy=%b hi=%h lo=%h expected 0/1/2", busy, hi, lo);
      end
   endtask

   task automatic test_reset_mid();
      write_hilo(32'h0000_ABCD, 32'h0000_1234);
      op = 2'b00; a = 32'd7; b = 32'd9; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2 reset = 1'b1;
      #1;
      vectors++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
      end
      #2 reset = 1'b0;
      repeat (LAT_MUL + 1) tick();
      vectors++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL reset_mid_after: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      run_op(2'b00, 32'd5, 32'd6, n);
      vectors++; if (hi !== 32'd0 || lo !== 32'd30 || n != LAT_MUL) begin
         errors++; $display("FAIL b2b_mult: got hi=%h lo=%h lat=%0d expected 0/1e/%0d", hi, lo, n, LAT_MUL);
      end
      run_op(2'b11, 32'd100, 32'd7, n);
      vectors++; if (hi !== 32'd2 || lo !== 32'd14 || n != LAT_DIV) begin
         errors++; $display("FAIL b2b_divu: got hi=%h lo=%h lat=%0d expected 2/e/33", hi, lo, n);
      end
   endtask

   task automatic test_random();
      int n, mode, exp_lat;
      logic [1:0]  o;
      logic [31:0] x, y;
      logic [63:0] exp;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         mode = $urandom_range(0, 5);
         case (mode)
            0: y = 32'd0;
            1: y = 32'($urandom_range(1, 15));
            2: begin x = 32'h8000_0000; y = (($urandom & 1) != 0) ? 32'hFFFF_FFFF : 32'd1; end
            3: x = 32'($urandom_range(0, 1000));
            default: y = y;
         endcase
         exp = ref_model(o, x, y);
         exp_lat = o[1] ? LAT_DIV : LAT_MUL;
         run_op(o, x, y, n);
         vectors++; if ({hi, lo} !== exp || n != exp_lat) begin
            errors++;
            $display("FAIL random_%0d op=%0d a=%h b=%h: got %h_%h lat=%0d expected %h_%h lat=%0d",
                     i, o, x, y, hi, lo, n, exp[63:32], exp[31:0], exp_lat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_busy_ignore();
      test_start_mthi();
      test_cancel();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
